// File: rtl/irq_pending_arbiter_16.sv
// irq_pending_arbiter_16: sequential front end for the 16-line priority encode path.
// It captures request lines into a pending register and applies a per-line mask.
// The highest-index unmasked pending line is presented on a valid/ack handshake.
// The registered masked-pending vector is exported for a downstream 16:4 encoder.
module irq_pending_arbiter_16 #(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic        Clock_In,
  input  logic        Reset_In,
  input  logic        Enable_In,
  input  logic [15:0] Irq_In,
  input  logic        Mask_Wr_En_In,
  input  logic [15:0] Mask_Data_In,
  input  logic        Irq_Ack_In,
  output logic        Irq_Valid_Out,
  output logic [3:0]  Irq_Id_Out,
  output logic [15:0] Pending_Out,
  output logic [15:0] Mask_Out
);

  localparam int NUM_LINES = 16;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t                 state;
  logic [NUM_LINES-1:0]   pending, mask, irq_prev;
  logic [NUM_LINES-1:0]   set_vec, clr_vec, pending_nxt, mask_nxt, eligible;
  logic [3:0]             top_id;
  logic                   any_elig;

  assign Mask_Out = mask;

  // Next-state of the pending/mask registers; a new set beats a same-cycle ack clear.
  always_comb begin
    set_vec = EDGE_MODE ? (Irq_In & ~irq_prev) : Irq_In;
    clr_vec = '0;
    if (state == PRESENT && Irq_Ack_In) clr_vec[Irq_Id_Out] = 1'b1;
    pending_nxt = (pending & ~clr_vec) | set_vec;
    mask_nxt    = Mask_Wr_En_In ? Mask_Data_In : mask;
    eligible    = pending & ~mask;
  end

  // Highest-index eligible line; later iterations overwrite, so bit 15 wins.
  always_comb begin
    top_id = '0;
    for (int i = 0; i < NUM_LINES; i++)
      if (eligible[i]) top_id = 4'(i);
    any_elig = |eligible;
  end

  // Capture state: pending bits, mask, previous request sample and exported vector.
  // irq_prev resets to all ones so lines held high through reset are not seen as edges.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      pending     <= '0;
      mask        <= '0;
      irq_prev    <= '1;
      Pending_Out <= '0;
    end else begin
      pending     <= pending_nxt;
      mask        <= mask_nxt;
      irq_prev    <= Irq_In;
      Pending_Out <= pending_nxt & ~mask_nxt;
    end
  end

  // Handshake FSM: once presented, an ID is held until acked, regardless of
  // enable, masking or higher-priority arrivals. The ID register keeps its value on ack.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state         <= IDLE;
      Irq_Valid_Out <= 1'b0;
      Irq_Id_Out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Enable_In && any_elig) begin
            state         <= PRESENT;
            Irq_Valid_Out <= 1'b1;
            Irq_Id_Out    <= top_id;
          end
        end
        PRESENT: begin
          if (Irq_Ack_In) begin
            state         <= IDLE;
            Irq_Valid_Out <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          Irq_Valid_Out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_arbiter_16.sv
// Directed bench for irq_pending_arbiter_16: an edge-mode DUT and a level-mode DUT
// share the stimulus; the level-mode one is only checked after its own reset.
module tb_irq_pending_arbiter_16;

  logic        gclk = 1'b0;
  logic        rst, en, mwe, ack;
  logic [15:0] irq, mdata;

  logic        vld_e, vld_l;
  logic [3:0]  id_e, id_l;
  logic [15:0] pend_e, pend_l, mask_e, mask_l;

  int n_chk = 0;
  int n_bad = 0;

  always #5 gclk = ~gclk;

  irq_pending_arbiter_16 #(.EDGE_MODE(1'b1)) u_edge (
    .Clock_In(gclk), .Reset_In(rst), .Enable_In(en), .Irq_In(irq),
    .Mask_Wr_En_In(mwe), .Mask_Data_In(mdata), .Irq_Ack_In(ack),
    .Irq_Valid_Out(vld_e), .Irq_Id_Out(id_e), .Pending_Out(pend_e), .Mask_Out(mask_e)
  );

  irq_pending_arbiter_16 #(.EDGE_MODE(1'b0)) u_lvl (
    .Clock_In(gclk), .Reset_In(rst), .Enable_In(en), .Irq_In(irq),
    .Mask_Wr_En_In(mwe), .Mask_Data_In(mdata), .Irq_Ack_In(ack),
    .Irq_Valid_Out(vld_l), .Irq_Id_Out(id_l), .Pending_Out(pend_l), .Mask_Out(mask_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs are changed and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mwe = 1'b0; ack = 1'b0; irq = '0; mdata = '0;
    tick(); tick();
    chk("rst_vld", {31'b0, vld_e}, 32'd0);
    chk("rst_id", {28'b0, id_e}, 32'd0);
    chk("rst_pend", {16'b0, pend_e}, 32'd0);
    chk("rst_mask", {16'b0, mask_e}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: single pulse on line 0, two-edge latency
    irq = 16'h0001; tick();
    chk("t1_pend_set", {16'b0, pend_e}, 32'h0001);
    chk("t1_vld_early", {31'b0, vld_e}, 32'd0);
    irq = 16'h0000; tick();
    chk("t1_vld", {31'b0, vld_e}, 32'd1);
    chk("t1_id", {28'b0, id_e}, 32'd0);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t1_vld_ack", {31'b0, vld_e}, 32'd0);
    chk("t1_pend_ack", {16'b0, pend_e}, 32'h0000);
    // ack in IDLE is ignored
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t1_idle_ack", {31'b0, vld_e}, 32'd0);

    // 2: simultaneous rise, priority order 15,10,5,0
    begin
      logic [3:0]  exp_id [4];
      logic [15:0] exp_pd [4];
      exp_id = '{4'd15, 4'd10, 4'd5, 4'd0};
      exp_pd = '{16'h0421, 16'h0021, 16'h0001, 16'h0000};
      irq = 16'h8421; tick();
      chk("t2_pend", {16'b0, pend_e}, 32'h8421);
      for (int i = 0; i < 4; i++) begin
        tick();
        chk("t2_vld", {31'b0, vld_e}, 32'd1);
        chk("t2_id", {28'b0, id_e}, {28'b0, exp_id[i]});
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t2_gap", {31'b0, vld_e}, 32'd0);
        chk("t2_pend_step", {16'b0, pend_e}, {16'b0, exp_pd[i]});
      end
      irq = 16'h0000; tick();
      chk("t2_quiet", {31'b0, vld_e}, 32'd0);
    end

    // 3: masked line accumulates and appears after unmask
    mwe = 1'b1; mdata = 16'h8000; tick(); mwe = 1'b0;
    chk("t3_mask", {16'b0, mask_e}, 32'h8000);
    irq = 16'h8008; tick(); irq = 16'h0000;
    chk("t3_pend_masked", {16'b0, pend_e}, 32'h0008);
    tick();
    chk("t3_id3", {28'b0, id_e}, 32'd3);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t3_pend_after", {16'b0, pend_e}, 32'h0000);
    mwe = 1'b1; mdata = 16'h0000; tick(); mwe = 1'b0;
    chk("t3_pend_unmask", {16'b0, pend_e}, 32'h8000);
    chk("t3_vld_lag", {31'b0, vld_e}, 32'd0);
    tick();
    chk("t3_vld15", {31'b0, vld_e}, 32'd1);
    chk("t3_id15", {28'b0, id_e}, 32'd15);
    ack = 1'b1; tick(); ack = 1'b0;

    // 4: presented ID held while higher-priority line arrives
    irq = 16'h0004; tick(); irq = 16'h0000; tick();
    chk("t4_id2", {28'b0, id_e}, 32'd2);
    irq = 16'h4000;
    for (int i = 0; i < 5; i++) begin
      tick(); irq = 16'h0000;
      chk("t4_hold_vld", {31'b0, vld_e}, 32'd1);
      chk("t4_hold_id", {28'b0, id_e}, 32'd2);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t4_pend_14", {16'b0, pend_e}, 32'h4000);
    tick();
    chk("t4_id14", {28'b0, id_e}, 32'd14);
    ack = 1'b1; tick(); ack = 1'b0;

    // 5: enable low suppresses presentation but not capture
    en = 1'b0; irq = 16'h0080; tick(); irq = 16'h0000; tick(); tick();
    chk("t5_vld_off", {31'b0, vld_e}, 32'd0);
    chk("t5_pend", {16'b0, pend_e}, 32'h0080);
    en = 1'b1; tick();
    chk("t5_vld_on", {31'b0, vld_e}, 32'd1);
    chk("t5_id7", {28'b0, id_e}, 32'd7);
    ack = 1'b1; tick(); ack = 1'b0;

    // 7: new edge coinciding with ack of the same ID -> set wins, re-presented
    irq = 16'h0002; tick(); irq = 16'h0000; tick();
    chk("t7_id1", {28'b0, id_e}, 32'd1);
    irq = 16'h0002; ack = 1'b1; tick(); ack = 1'b0; irq = 16'h0000;
    chk("t7_vld_ack", {31'b0, vld_e}, 32'd0);
    chk("t7_pend_kept", {16'b0, pend_e}, 32'h0002);
    tick();
    chk("t7_re_vld", {31'b0, vld_e}, 32'd1);
    chk("t7_re_id", {28'b0, id_e}, 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;

    // 6: level mode re-presents a held line; reset mid-handshake clears everything
    rst = 1'b1; tick(); rst = 1'b0;
    irq = 16'h0010; tick();
    chk("t6_lvl_pend", {16'b0, pend_l}, 32'h0010);
    chk("t6_edge_noedge", {16'b0, pend_e}, 32'h0000);
    tick();
    chk("t6_lvl_vld", {31'b0, vld_l}, 32'd1);
    chk("t6_lvl_id", {28'b0, id_l}, 32'd4);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t6_lvl_gap", {31'b0, vld_l}, 32'd0);
    chk("t6_lvl_pend2", {16'b0, pend_l}, 32'h0010);
    tick();
    chk("t6_lvl_re_vld", {31'b0, vld_l}, 32'd1);
    chk("t6_lvl_re_id", {28'b0, id_l}, 32'd4);
    irq = 16'h0000; rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_vld", {31'b0, vld_l}, 32'd0);
    chk("t6_rst_id", {28'b0, id_l}, 32'd0);
    chk("t6_rst_pend", {16'b0, pend_l}, 32'h0000);
    tick();
    chk("t6_rst_stay", {31'b0, vld_l}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
